// File: rtl/ps2_keymap_pkg.sv
// Shared scancode-set-2 constants, prefix-state encoding and small helpers
// used by the PS/2 keymap consumer stage.
package ps2_keymap_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;

  // Controller replies and error codes; never keystrokes.
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR_LO = 8'h00;
  localparam logic [7:0] SC_ERR_HI = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_state_e;

  typedef struct packed {
    logic       hit;
    logic [7:0] ch;
  } xlate_t;

  function automatic logic [7:0] bit_reverse(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic is_reply(input logic [7:0] b);
    return (b == SC_BAT_OK) || (b == SC_ACK)    || (b == SC_ECHO) ||
           (b == SC_RESEND) || (b == SC_ERR_LO) || (b == SC_ERR_HI);
  endfunction

endpackage

// File: rtl/ascii_fifo.sv
// Synchronous first-word-fall-through FIFO holding translated characters.
// Pushes into a full FIFO are dropped; pops of an empty FIFO are ignored.
module ascii_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign count   = count_q;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth lets the pointers wrap by natural overflow.
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately left unreset; empty gates dout, so stale
  // entries are never visible and the array can map onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ps2_keymap.sv
// Scancode-set-2 to ASCII translator: tracks break/extended prefixes and the
// Shift/Caps modifiers, and buffers translated characters in ascii_fifo.
module ps2_keymap #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] ENTER_CHAR = 8'h0D
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cap,
  input  logic [7:0] i_dap,
  output logic       o_spa,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ack,
  output logic       o_shift,
  output logic       o_caps
);

  import ps2_keymap_pkg::*;

  localparam int              CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] SPA_LIMIT = CNT_W'(FIFO_DEPTH - 2);

  prefix_state_e    state_q, state_d;
  logic             lshift_q, lshift_d;
  logic             rshift_q, rshift_d;
  logic             caps_q, caps_d;
  logic             caps_held_q, caps_held_d;
  logic             wr_valid_q, wr_valid_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [7:0]       sc;
  logic             accept;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  xlate_t           xl;

  function automatic xlate_t letter_lookup(input logic [7:0] code);
    xlate_t r;
    r = '{hit: 1'b1, ch: 8'h00};
    case (code)
      8'h1C: r.ch = "a";  8'h32: r.ch = "b";  8'h21: r.ch = "c";
      8'h23: r.ch = "d";  8'h24: r.ch = "e";  8'h2B: r.ch = "f";
      8'h34: r.ch = "g";  8'h33: r.ch = "h";  8'h43: r.ch = "i";
      8'h3B: r.ch = "j";  8'h42: r.ch = "k";  8'h4B: r.ch = "l";
      8'h3A: r.ch = "m";  8'h31: r.ch = "n";  8'h44: r.ch = "o";
      8'h4D: r.ch = "p";  8'h15: r.ch = "q";  8'h2D: r.ch = "r";
      8'h1B: r.ch = "s";  8'h2C: r.ch = "t";  8'h3C: r.ch = "u";
      8'h2A: r.ch = "v";  8'h1D: r.ch = "w";  8'h22: r.ch = "x";
      8'h35: r.ch = "y";  8'h1A: r.ch = "z";
      default: r.hit = 1'b0;
    endcase
    return r;
  endfunction

  function automatic xlate_t translate(input logic [7:0] code,
                                       input logic       shift,
                                       input logic       caps);
    xlate_t l;
    xlate_t r;
    l = letter_lookup(code);
    r = '{hit: 1'b1, ch: 8'h00};
    // Clearing bit 5 turns a lowercase ASCII letter into its uppercase form.
    if (l.hit) begin
      r.ch = (shift ^ caps) ? (l.ch & 8'hDF) : l.ch;
    end else begin
      case (code)
        8'h16:    r.ch = shift ? "!" : "1";
        8'h1E:    r.ch = shift ? "@" : "2";
        8'h26:    r.ch = shift ? "#" : "3";
        8'h25:    r.ch = shift ? "$" : "4";
        8'h2E:    r.ch = shift ? "%" : "5";
        8'h36:    r.ch = shift ? "^" : "6";
        8'h3D:    r.ch = shift ? "&" : "7";
        8'h3E:    r.ch = shift ? "*" : "8";
        8'h46:    r.ch = shift ? "(" : "9";
        8'h45:    r.ch = shift ? ")" : "0";
        8'h4E:    r.ch = shift ? "_" : "-";
        8'h55:    r.ch = shift ? "+" : "=";
        8'h41:    r.ch = shift ? "<" : ",";
        8'h49:    r.ch = shift ? ">" : ".";
        8'h4A:    r.ch = shift ? "?" : "/";
        8'h29:    r.ch = 8'h20;
        8'h66:    r.ch = 8'h08;
        8'h0D:    r.ch = 8'h09;
        SC_ENTER: r.ch = ENTER_CHAR;
        default:  r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

  assign sc      = bit_reverse(i_dap);
  assign o_spa   = (fifo_count <= SPA_LIMIT);
  assign accept  = i_cap & o_spa;
  assign o_shift = lshift_q | rshift_q;
  assign o_caps  = caps_q;
  assign o_valid = ~fifo_empty;
  assign xl      = translate(sc, lshift_q | rshift_q, caps_q);

  always_comb begin
    state_d     = state_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    wr_valid_d  = 1'b0;
    wr_data_d   = wr_data_q;
    if (accept) begin
      if (is_reply(sc)) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (sc == SC_BREAK) begin
              state_d = ST_BRK;
            end else if (sc == SC_EXT) begin
              state_d = ST_EXT;
            end else begin
              if (sc == SC_LSHIFT) lshift_d = 1'b1;
              if (sc == SC_RSHIFT) rshift_d = 1'b1;
              // Typematic repeats of Caps Lock must not re-toggle the latch.
              if (sc == SC_CAPS) begin
                if (!caps_held_q) caps_d = ~caps_q;
                caps_held_d = 1'b1;
              end
              if (xl.hit) begin
                wr_valid_d = 1'b1;
                wr_data_d  = xl.ch;
              end
            end
          end
          ST_BRK: begin
            if (sc == SC_LSHIFT) lshift_d    = 1'b0;
            if (sc == SC_RSHIFT) rshift_d    = 1'b0;
            if (sc == SC_CAPS)   caps_held_d = 1'b0;
            state_d = ST_IDLE;
          end
          ST_EXT: begin
            if (sc == SC_BREAK) begin
              state_d = ST_EXT_BRK;
            end else begin
              state_d = ST_IDLE;
              if (sc == SC_ENTER) begin
                wr_valid_d = 1'b1;
                wr_data_d  = ENTER_CHAR;
              end
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // NOTE: reset is sampled on the clock edge only; the port is a plain
  // synchronous input, so it never appears in the sensitivity list.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      wr_valid_q  <= wr_valid_d;
      wr_data_q   <= wr_data_d;
    end
  end

  ascii_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (wr_valid_q),
    .din     (wr_data_q),
    .pop     (i_ack),
    .dout    (o_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_ps2_keymap.sv
// Self-checking bench for ps2_keymap: directed scenarios plus a randomized
// keystroke stream scored against a table-driven keyboard model.
module tb_ps2_keymap;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_cap;
  logic [7:0] i_dap;
  logic       i_ack;
  logic       o_spa;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_shift;
  logic       o_caps;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_keymap #(.FIFO_DEPTH(4), .ENTER_CHAR(8'h0D)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_cap   (i_cap),
    .i_dap   (i_dap),
    .o_spa   (o_spa),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ack   (i_ack),
    .o_shift (o_shift),
    .o_caps  (o_caps)
  );

  // Keyboard model: layout tables plus modifier/prefix flags.
  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_sc [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                                8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
  logic [7:0] punct_sc [5]  = '{8'h4E, 8'h55, 8'h41, 8'h49, 8'h4A};
  string digit_lo = "1234567890";
  string digit_hi = "!@#$%^&*()";
  string punct_lo = "-=,./";
  string punct_hi = "_+<>?";

  bit m_shl, m_shr, m_caps, m_held, m_brk, m_ext;
  logic [7:0] m_q[$];

  function automatic int model_xlate(input logic [7:0] sc, input bit sh, input bit cp);
    for (int i = 0; i < 26; i++)
      if (sc == letter_sc[i]) return (sh ^ cp) ? 65 + i : 97 + i;
    for (int i = 0; i < 10; i++)
      if (sc == digit_sc[i]) return sh ? int'(digit_hi[i]) : int'(digit_lo[i]);
    for (int i = 0; i < 5; i++)
      if (sc == punct_sc[i]) return sh ? int'(punct_hi[i]) : int'(punct_lo[i]);
    case (sc)
      8'h29:   return 32;
      8'h66:   return 8;
      8'h5A:   return 13;
      8'h0D:   return 9;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_shl = 0; m_shr = 0; m_caps = 0; m_held = 0; m_brk = 0; m_ext = 0;
    m_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] sc);
    int ch;
    if (sc inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
      m_brk = 0; m_ext = 0;
    end else if (m_ext && m_brk) begin
      m_ext = 0; m_brk = 0;
    end else if (m_ext) begin
      if (sc == 8'hF0) m_brk = 1;
      else begin
        m_ext = 0;
        if (sc == 8'h5A) m_q.push_back(8'h0D);
      end
    end else if (m_brk) begin
      m_brk = 0;
      if (sc == 8'h12) m_shl = 0;
      if (sc == 8'h59) m_shr = 0;
      if (sc == 8'h58) m_held = 0;
    end else if (sc == 8'hF0) begin
      m_brk = 1;
    end else if (sc == 8'hE0) begin
      m_ext = 1;
    end else begin
      ch = model_xlate(sc, m_shl | m_shr, m_caps);
      if (ch >= 0) m_q.push_back(8'(ch));
      if (sc == 8'h12) m_shl = 1;
      if (sc == 8'h59) m_shr = 1;
      if (sc == 8'h58) begin
        if (!m_held) m_caps = ~m_caps;
        m_held = 1;
      end
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // All tasks start and end just after a falling clock edge.
  task automatic do_reset();
    rst_n = 1'b0; i_cap = 1'b0; i_ack = 1'b0; i_dap = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic send_byte(input logic [7:0] sc);
    int n = 0;
    while (o_spa !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (o_spa !== 1'b1) begin
      checks++; errors++;
      $display("FAIL spa_timeout: o_spa=%b after %0d cycles, required 1", o_spa, n);
    end
    i_dap = rev8(sc);
    i_cap = 1'b1;
    model_byte(sc);
    @(negedge clk);
    i_cap = 1'b0;
  endtask

  task automatic pop_one();
    i_ack = 1'b1;
    @(negedge clk);
    i_ack = 1'b0;
  endtask

  task automatic drain_some(input int max_pops);
    for (int k = 0; k < max_pops; k++) begin
      if (o_valid !== 1'b1) break;
      checks++;
      if (m_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_char: got %h, model expected no char", o_data);
      end else if (o_data !== m_q[0]) begin
        errors++;
        $display("FAIL stream_char: got %h expected %h", o_data, m_q[0]);
      end
      if (m_q.size() != 0) void'(m_q.pop_front());
      pop_one();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({o_valid, o_data, o_shift, o_caps, o_spa} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h shift=%b caps=%b spa=%b, required 0 00 0 0 1",
               o_valid, o_data, o_shift, o_caps, o_spa);
    end
  endtask

  task automatic test_latency();
    do_reset();
    send_byte(8'h1C);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL latency_early: o_valid=%b one cycle after cap, required 0", o_valid);
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h61) begin
      errors++; $display("FAIL latency_char: valid=%b data=%h, required 1 61", o_valid, o_data);
    end
    pop_one();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL latency_pop: o_valid=%b after ack, required 0", o_valid);
    end
    m_q.delete();
  endtask

  task automatic test_shift();
    do_reset();
    send_byte(8'h12);
    checks++;
    if (o_shift !== 1'b1) begin
      errors++; $display("FAIL shift_held: o_shift=%b, required 1", o_shift);
    end
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h12);
    checks++;
    if (o_shift !== 1'b0) begin
      errors++; $display("FAIL shift_release: o_shift=%b, required 0", o_shift);
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h41) begin
      errors++; $display("FAIL shift_char: valid=%b data=%h, required 1 41", o_valid, o_data);
    end
    pop_one();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL shift_extra: o_valid=%b data=%h, required no further char", o_valid, o_data);
    end
    send_byte(8'h59); send_byte(8'h16); send_byte(8'hF0); send_byte(8'h59); send_byte(8'h4A);
    @(negedge clk);
    checks++;
    if (o_data !== 8'h21) begin
      errors++; $display("FAIL rshift_digit: got %h expected 21", o_data);
    end
    pop_one();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h2F) begin
      errors++; $display("FAIL unshifted_punct: valid=%b data=%h, required 1 2f", o_valid, o_data);
    end
    pop_one();
    m_q.delete();
  endtask

  task automatic test_caps();
    do_reset();
    send_byte(8'h58); send_byte(8'h58); send_byte(8'h58);
    send_byte(8'hF0); send_byte(8'h58); send_byte(8'h1C);
    @(negedge clk);
    checks++;
    if (o_caps !== 1'b1 || o_data !== 8'h41) begin
      errors++; $display("FAIL caps_single_toggle: caps=%b data=%h, required 1 41", o_caps, o_data);
    end
    pop_one();
    send_byte(8'h12); send_byte(8'h1C);
    @(negedge clk);
    checks++;
    if (o_data !== 8'h61) begin
      errors++; $display("FAIL shift_xor_caps: got %h expected 61", o_data);
    end
    pop_one();
    send_byte(8'hF0); send_byte(8'h12); send_byte(8'h16);
    @(negedge clk);
    checks++;
    if (o_data !== 8'h31) begin
      errors++; $display("FAIL caps_digit: got %h expected 31", o_data);
    end
    pop_one();
    send_byte(8'h58);
    checks++;
    if (o_caps !== 1'b0) begin
      errors++; $display("FAIL caps_retoggle: o_caps=%b, required 0", o_caps);
    end
    m_q.delete();
  endtask

  task automatic test_ext();
    do_reset();
    send_byte(8'hE0); send_byte(8'h5A);
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h0D) begin
      errors++; $display("FAIL kp_enter: valid=%b data=%h, required 1 0d", o_valid, o_data);
    end
    pop_one();
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h5A);
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hAA); send_byte(8'hFA);
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL ext_silent: o_valid=%b data=%h, required no char", o_valid, o_data);
    end
    send_byte(8'hE0); send_byte(8'hAA); send_byte(8'hF0); send_byte(8'hFA); send_byte(8'h1C);
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h61) begin
      errors++; $display("FAIL reply_to_idle: valid=%b data=%h, required 1 61", o_valid, o_data);
    end
    pop_one();
    m_q.delete();
  endtask

  task automatic test_fifo_full();
    logic [7:0] exp_chars [3] = '{8'h61, 8'h62, 8'h63};
    do_reset();
    send_byte(8'h1C); @(negedge clk);
    send_byte(8'h32); @(negedge clk);
    checks++;
    if (o_spa !== 1'b1) begin
      errors++; $display("FAIL spa_two_free: o_spa=%b with 2 stored, required 1", o_spa);
    end
    send_byte(8'h21); @(negedge clk);
    checks++;
    if (o_spa !== 1'b0) begin
      errors++; $display("FAIL spa_one_free: o_spa=%b with 3 stored, required 0", o_spa);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_valid !== 1'b1 || o_data !== exp_chars[k]) begin
        errors++; $display("FAIL fifo_order_%0d: valid=%b data=%h, required 1 %h",
                           k, o_valid, o_data, exp_chars[k]);
      end
      pop_one();
    end
    checks++;
    if (o_valid !== 1'b0 || o_spa !== 1'b1) begin
      errors++; $display("FAIL fifo_drained: valid=%b spa=%b, required 0 1", o_valid, o_spa);
    end
    send_byte(8'h1C); @(negedge clk);
    send_byte(8'h32);
    pop_one();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h62) begin
      errors++; $display("FAIL push_pop_same: valid=%b data=%h, required 1 62", o_valid, o_data);
    end
    pop_one();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL push_pop_count: o_valid=%b after last pop, required 0", o_valid);
    end
    m_q.delete();
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_byte(8'hF0);
    do_reset();
    send_byte(8'h1C);
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h61) begin
      errors++; $display("FAIL reset_drops_prefix: valid=%b data=%h, required 1 61", o_valid, o_data);
    end
    pop_one();
    send_byte(8'h32); send_byte(8'h21);
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1) begin
      errors++; $display("FAIL queued_before_reset: o_valid=%b, required 1", o_valid);
    end
    do_reset();
    checks++;
    if (o_valid !== 1'b0 || o_data !== 8'h00) begin
      errors++; $display("FAIL reset_flush: valid=%b data=%h, required 0 00", o_valid, o_data);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool[$];
    logic [7:0] pick;
    foreach (letter_sc[i]) pool.push_back(letter_sc[i]);
    foreach (digit_sc[i])  pool.push_back(digit_sc[i]);
    foreach (punct_sc[i])  pool.push_back(punct_sc[i]);
    pool.push_back(8'h29); pool.push_back(8'h66); pool.push_back(8'h5A); pool.push_back(8'h0D);
    for (int i = 0; i < 8; i++) pool.push_back(8'hF0);
    for (int i = 0; i < 3; i++) begin
      pool.push_back(8'hE0); pool.push_back(8'h12); pool.push_back(8'h59); pool.push_back(8'h58);
    end
    pool.push_back(8'hAA); pool.push_back(8'hFA); pool.push_back(8'hEE);
    pool.push_back(8'hFE); pool.push_back(8'h00); pool.push_back(8'hFF);
    pool.push_back(8'h75); pool.push_back(8'h14);
    do_reset();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) drain_some(int'($urandom_range(1, 4)));
      if (o_spa !== 1'b1) drain_some(2);
      pick = pool[$urandom_range(0, pool.size() - 1)];
      send_byte(pick);
      checks++;
      if (o_shift !== (m_shl | m_shr) || o_caps !== m_caps) begin
        errors++; $display("FAIL rand_modifiers: byte %h shift=%b caps=%b, required %b %b",
                           pick, o_shift, o_caps, m_shl | m_shr, m_caps);
      end
    end
    @(negedge clk);
    drain_some(16);
    checks++;
    if (o_valid !== 1'b0 || m_q.size() != 0) begin
      errors++; $display("FAIL rand_leftover: o_valid=%b, model still expects %0d chars",
                         o_valid, m_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; i_cap = 1'b0; i_ack = 1'b0; i_dap = 8'h00;
    @(negedge clk);
    test_reset();
    test_latency();
    test_shift();
    test_caps();
    test_ext();
    test_fifo_full();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
